// File: rtl/otter_pkg.sv
// Shared OTTER types: next-PC source encoding, fetch sequencer states and
// the instruction word width.
package otter_pkg;

   localparam int INSTR_W = 32;

   typedef enum logic [2:0] {
      PC_PLUS4  = 3'd0,
      PC_JALR   = 3'd1,
      PC_BRANCH = 3'd2,
      PC_JAL    = 3'd3,
      PC_MTVEC  = 3'd4,
      PC_MEPC   = 3'd5
   } pc_src_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } fetch_state_t;

   // Sources 1..5 are control-flow targets; 0, 6 and 7 fall through to pc+4.
   function automatic logic is_target_src(input logic [2:0] src);
      return (src >= 3'(PC_JALR)) && (src <= 3'(PC_MEPC));
   endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC select. Control-flow targets are word-aligned by clearing bits
// [1:0]; the sequential pc+4 path is passed through untouched.
module pc_next_mux
   import otter_pkg::*;
#(
   parameter int PC_W = 10
) (
   input  logic [2:0]      pc_source,
   input  logic [PC_W-1:0] pc_plus4,
   input  logic [PC_W-1:0] jalr,
   input  logic [PC_W-1:0] branch,
   input  logic [PC_W-1:0] jal,
   input  logic [PC_W-1:0] mtvec,
   input  logic [PC_W-1:0] mepc,
   output logic [PC_W-1:0] next_pc,
   output logic            misalign_raw
);

   logic [PC_W-1:0] target;

   always_comb begin
      target = pc_plus4;
      case (pc_source)
         PC_JALR:   target = jalr;
         PC_BRANCH: target = branch;
         PC_JAL:    target = jal;
         PC_MTVEC:  target = mtvec;
         PC_MEPC:   target = mepc;
         default:   target = pc_plus4;
      endcase
   end

   always_comb begin
      next_pc      = pc_plus4;
      misalign_raw = 1'b0;
      if (is_target_src(pc_source)) begin
         next_pc      = {target[PC_W-1:2], 2'b00};
         misalign_raw = |target[1:0];
      end
   end

endmodule

// File: rtl/otter_pc_fetch.sv
// OTTER program counter and instruction-fetch sequencer: request/ack fetch
// from instruction memory, valid/ready hand-off of the fetched word to decode.
module otter_pc_fetch
   import otter_pkg::*;
#(
   parameter int              PC_W     = 10,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic               CLK,
   input  logic               RST,
   output logic [PC_W-1:0]    COUNT,
   input  logic [PC_W-1:0]    PC_PLUS4,
   input  logic [2:0]         PC_SOURCE,
   input  logic [PC_W-1:0]    JALR,
   input  logic [PC_W-1:0]    BRANCH,
   input  logic [PC_W-1:0]    JAL,
   input  logic [PC_W-1:0]    MTVEC,
   input  logic [PC_W-1:0]    MEPC,
   output logic               IMEM_REQ,
   output logic [PC_W-1:0]    IMEM_ADDR,
   input  logic               IMEM_ACK,
   input  logic [INSTR_W-1:0] IMEM_DATA,
   output logic               IR_VALID,
   output logic [INSTR_W-1:0] IR,
   output logic [PC_W-1:0]    IR_PC,
   input  logic               IR_READY,
   output logic               MISALIGN
);

   fetch_state_t       state;
   logic [PC_W-1:0]    count;
   logic [INSTR_W-1:0] ir;
   logic [PC_W-1:0]    ir_pc;
   logic               imem_req;
   logic               ir_valid;
   logic               misalign;

   logic [PC_W-1:0]    next_pc;
   logic               misalign_raw;

   pc_next_mux #(
      .PC_W (PC_W)
   ) u_next (
      .pc_source    (PC_SOURCE),
      .pc_plus4     (PC_PLUS4),
      .jalr         (JALR),
      .branch       (BRANCH),
      .jal          (JAL),
      .mtvec        (MTVEC),
      .mepc         (MEPC),
      .next_pc      (next_pc),
      .misalign_raw (misalign_raw)
   );

   // Request and valid flags are registered alongside the state so they
   // change on the same edge as the state they describe.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= IDLE;
         count    <= RESET_PC;
         ir       <= '0;
         ir_pc    <= '0;
         imem_req <= 1'b0;
         ir_valid <= 1'b0;
         misalign <= 1'b0;
      end else begin
         misalign <= 1'b0;
         case (state)
            IDLE: begin
               state    <= REQ;
               imem_req <= 1'b1;
               ir_valid <= 1'b0;
            end
            REQ: begin
               if (IMEM_ACK) begin
                  ir       <= IMEM_DATA;
                  ir_pc    <= count;
                  state    <= HOLD;
                  imem_req <= 1'b0;
                  ir_valid <= 1'b1;
               end
            end
            HOLD: begin
               // COUNT only moves here, so PC_PLUS4 stays valid through HOLD.
               if (IR_READY) begin
                  count    <= next_pc;
                  misalign <= misalign_raw;
                  state    <= REQ;
                  imem_req <= 1'b1;
                  ir_valid <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               imem_req <= 1'b0;
               ir_valid <= 1'b0;
            end
         endcase
      end
   end

   assign COUNT     = count;
   assign IMEM_ADDR = count;
   assign IMEM_REQ  = imem_req;
   assign IR_VALID  = ir_valid;
   assign IR        = ir;
   assign IR_PC     = ir_pc;
   assign MISALIGN  = misalign;

endmodule

// File: tb/tb_otter_pc_fetch.sv
// Bench for otter_pc_fetch: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a transaction-level model.
module tb_otter_pc_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [9:0]  count, pc_plus4, imem_addr, ir_pc;
   logic [2:0]  pc_source = 3'd0;
   logic [9:0]  jalr = '0, branch = '0, jal = '0, mtvec = '0, mepc = '0;
   logic        imem_req, imem_ack = 1'b0, ir_valid, ir_ready = 1'b0, misalign;
   logic [31:0] imem_data = '0, ir;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   // The bench plays the external PC+4 adder.
   assign pc_plus4 = count + 10'd4;

   otter_pc_fetch #(.PC_W(10), .RESET_PC(10'd0)) dut (
      .CLK       (clk),
      .RST       (rst),
      .COUNT     (count),
      .PC_PLUS4  (pc_plus4),
      .PC_SOURCE (pc_source),
      .JALR      (jalr),
      .BRANCH    (branch),
      .JAL       (jal),
      .MTVEC     (mtvec),
      .MEPC      (mepc),
      .IMEM_REQ  (imem_req),
      .IMEM_ADDR (imem_addr),
      .IMEM_ACK  (imem_ack),
      .IMEM_DATA (imem_data),
      .IR_VALID  (ir_valid),
      .IR        (ir),
      .IR_PC     (ir_pc),
      .IR_READY  (ir_ready),
      .MISALIGN  (misalign)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // A fetch is either waiting to start, waiting on memory, or parked at decode.
   int          m_phase;   // 0 = just out of reset, 1 = awaiting memory, 2 = awaiting decode
   int          m_pc;
   logic [31:0] m_ir;
   int          m_irpc;
   bit          m_mis;

   function automatic int pick_target(input int src);
      case (src)
         1: return int'(jalr);
         2: return int'(branch);
         3: return int'(jal);
         4: return int'(mtvec);
         5: return int'(mepc);
         default: return -1;
      endcase
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase <= 0;
         m_pc    <= 0;
         m_ir    <= '0;
         m_irpc  <= 0;
         m_mis   <= 1'b0;
      end else begin
         m_mis <= 1'b0;
         if (m_phase == 0) begin
            m_phase <= 1;
         end else if (m_phase == 1) begin
            if (imem_ack) begin
               m_ir    <= imem_data;
               m_irpc  <= m_pc;
               m_phase <= 2;
            end
         end else if (ir_ready) begin
            if (pick_target(int'(pc_source)) >= 0) begin
               m_pc  <= pick_target(int'(pc_source)) - pick_target(int'(pc_source)) % 4;
               m_mis <= (pick_target(int'(pc_source)) % 4) != 0;
            end else begin
               m_pc <= (m_pc + 4) % 1024;
            end
            m_phase <= 1;
         end
      end
   end

   // One compare per output on every falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("COUNT",     32'(count),     32'(m_pc));
         check("IMEM_ADDR", 32'(imem_addr), 32'(m_pc));
         check("IMEM_REQ",  32'(imem_req),  32'(m_phase == 1));
         check("IR_VALID",  32'(ir_valid),  32'(m_phase == 2));
         check("IR",        ir,             m_ir);
         check("IR_PC",     32'(ir_pc),     32'(m_irpc));
         check("MISALIGN",  32'(misalign),  32'(m_mis));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic next_cycle();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      next_cycle();
      rst = 1'b1;
      repeat (2) next_cycle();
      rst = 1'b0;
   endtask

   // which: 0 waits for IMEM_REQ, 1 waits for IR_VALID; bounded to 20 cycles.
   task automatic wait_for(input int which, input string nm);
      for (int i = 0; i < 20; i++) begin
         next_cycle();
         if ((which == 0 && imem_req) || (which == 1 && ir_valid)) return;
      end
      check({nm, "_timeout"}, 32'd1, 32'd0);
   endtask

   initial begin
      int k;
      #1 rst = 1'b1;
      #1 chk_en = 1'b1;

      // Reset values
      repeat (2) next_cycle();
      check("rst_count", 32'(count), 32'h0);
      check("rst_req",   32'(imem_req), 32'h0);
      check("rst_valid", 32'(ir_valid), 32'h0);
      check("rst_ir",    ir, 32'h0);
      check("rst_mis",   32'(misalign), 32'h0);

      // Zero-wait streaming: addresses 0,4,8, valid every other cycle
      imem_ack = 1'b1; ir_ready = 1'b1; pc_source = 3'd0; imem_data = 32'h0000_0013;
      rst = 1'b0;
      k = 0;
      for (int i = 0; i < 6; i++) begin
         next_cycle();
         if (imem_req) begin
            check("stream_addr", 32'(imem_addr), 32'(k * 4));
            k++;
         end else begin
            check("stream_valid", 32'(ir_valid), 32'd1);
            check("stream_irpc", 32'(ir_pc), 32'((k - 1) * 4));
            check("stream_ir", ir, 32'h0000_0013);
         end
      end
      check("stream_fetches", 32'(k), 32'd3);

      // Decode stall on the instruction at 0x004
      do_reset();
      wait_for(1, "stall_v0");
      wait_for(1, "stall_v1");
      check("stall_start_irpc", 32'(ir_pc), 32'h004);
      ir_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         next_cycle();
         check("stall_count", 32'(count), 32'h004);
         check("stall_req",   32'(imem_req), 32'h0);
         check("stall_irpc",  32'(ir_pc), 32'h004);
      end
      ir_ready = 1'b1;
      wait_for(0, "stall_release");
      check("stall_next_addr", 32'(imem_addr), 32'h008);

      // Memory wait: ACK on the fourth REQ cycle
      imem_ack = 1'b0;
      do_reset();
      wait_for(0, "wait_req");
      for (int i = 0; i < 4; i++) begin
         check("wait_req_held", 32'(imem_req), 32'h1);
         check("wait_addr", 32'(imem_addr), 32'h000);
         imem_ack  = (i == 3);
         imem_data = (i == 3) ? 32'hCAFE_0013 : $urandom;
         next_cycle();
      end
      check("wait_valid", 32'(ir_valid), 32'h1);
      check("wait_ir", ir, 32'hCAFE_0013);

      // Redirect: JAL to 0x100, then misaligned JALR 0x206 -> 0x204
      imem_ack = 1'b1;
      do_reset();
      wait_for(1, "jal_hold");
      pc_source = 3'd3; jal = 10'h100;
      wait_for(0, "jal_req");
      check("jal_addr", 32'(imem_addr), 32'h100);
      check("jal_mis",  32'(misalign), 32'h0);
      pc_source = 3'd1; jalr = 10'h206;
      wait_for(1, "jalr_hold");
      wait_for(0, "jalr_req");
      check("jalr_addr", 32'(imem_addr), 32'h204);
      check("jalr_mis",  32'(misalign), 32'h1);
      next_cycle();
      check("jalr_mis_end", 32'(misalign), 32'h0);

      // Wrap from 0x3FC, then reserved source 7 acts as pc+4
      pc_source = 3'd0;
      do_reset();
      wait_for(1, "wrap_h0");
      pc_source = 3'd3; jal = 10'h3FC;
      wait_for(0, "wrap_r0");
      check("wrap_top", 32'(imem_addr), 32'h3FC);
      pc_source = 3'd0;
      wait_for(1, "wrap_h1");
      wait_for(0, "wrap_r1");
      check("wrap_addr", 32'(imem_addr), 32'h000);
      check("wrap_mis",  32'(misalign), 32'h0);
      pc_source = 3'd7;
      wait_for(1, "src7_h");
      wait_for(0, "src7_r");
      check("src7_addr", 32'(imem_addr), 32'h004);
      pc_source = 3'd0;

      // Async reset during REQ with an ACK in the same cycle
      imem_ack = 1'b0;
      do_reset();
      wait_for(0, "areset_req");
      imem_ack = 1'b1; imem_data = 32'h1234_5678;
      #1 rst = 1'b1;
      #1;
      check("areset_req",   32'(imem_req), 32'h0);
      check("areset_valid", 32'(ir_valid), 32'h0);
      check("areset_ir",    ir, 32'h0);
      check("areset_count", 32'(count), 32'h0);
      next_cycle();
      imem_ack = 1'b0;
      rst = 1'b0;
      wait_for(0, "areset_restart");
      check("areset_restart_addr", 32'(imem_addr), 32'h000);
      check("areset_ir_after", ir, 32'h0);

      // Randomized traffic, including occasional asynchronous resets
      for (int i = 0; i < 3000; i++) begin
         next_cycle();
         imem_ack  = ($urandom_range(0, 9) < 6);
         ir_ready  = ($urandom_range(0, 9) < 7);
         pc_source = 3'($urandom_range(0, 7));
         imem_data = $urandom;
         jalr      = 10'($urandom);
         branch    = 10'($urandom);
         jal       = 10'($urandom);
         mtvec     = 10'($urandom);
         mepc      = 10'($urandom);
         rst       = ($urandom_range(0, 299) == 0);
      end
      rst = 1'b0;
      repeat (3) next_cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
